// File: rtl/const_pkg.sv
// Shared constants and state encoding for the AXI-Lite MMIO master.
package const_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R,
        RSP
    } axi_master_state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_mmio_master_if.sv
// AXI4-Lite bus bundle between the MMIO master and an attached slave.
interface axi_lite_mmio_master_if;

    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/axi_lite_mmio_master.sv
// Single-outstanding AXI4-Lite master turning simple req/rsp commands
// into one AXI write or read transaction each.
module axi_lite_mmio_master
    import const_pkg::*;
#(
    parameter logic [2:0] AWPROT_VAL = 3'b000,
    parameter logic [2:0] ARPROT_VAL = 3'b000
) (
    input  logic        aclk,
    input  logic        arst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_write,
    axi_lite_mmio_master_if.master M_AXI,
    output logic        busy
);

    axi_master_state_t state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        write_q, write_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        arvalid_q, arvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  resp_q, resp_d;
    logic        rsp_write_q, rsp_write_d;

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            write_q     <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= AXI_RESP_OKAY;
            rsp_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            write_q     <= write_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            rsp_write_q <= rsp_write_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        write_d     = write_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
        rsp_write_d = rsp_write_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    write_d = req_write;
                    if (req_write) begin
                        state_d   = WR_AW_W;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_AR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_AW_W: begin
                // AW and W complete independently; leave once both are done
                if (awvalid_q && M_AXI.awready) awvalid_d = 1'b0;
                if (wvalid_q && M_AXI.wready) wvalid_d = 1'b0;
                if (!awvalid_d && !wvalid_d) state_d = WR_B;
            end
            WR_B: begin
                if (M_AXI.bvalid) begin
                    resp_d      = M_AXI.bresp;
                    rdata_d     = '0;
                    rsp_write_d = write_q;
                    state_d     = RSP;
                end
            end
            RD_AR: begin
                if (M_AXI.arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_R;
                end
            end
            RD_R: begin
                if (M_AXI.rvalid) begin
                    rdata_d     = M_AXI.rdata;
                    resp_d      = M_AXI.rresp;
                    rsp_write_d = write_q;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RSP);
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;
    assign rsp_write = rsp_write_q;

    assign M_AXI.awaddr  = addr_q;
    assign M_AXI.awprot  = AWPROT_VAL;
    assign M_AXI.awvalid = awvalid_q;
    assign M_AXI.wdata   = wdata_q;
    assign M_AXI.wstrb   = wstrb_q;
    assign M_AXI.wvalid  = wvalid_q;
    assign M_AXI.bready  = (state_q == WR_B);
    assign M_AXI.araddr  = addr_q;
    assign M_AXI.arprot  = ARPROT_VAL;
    assign M_AXI.arvalid = arvalid_q;
    assign M_AXI.rready  = (state_q == RD_R);

endmodule

// File: doc/axi_lite_mmio_master.md
AXI_LITE_MMIO_MASTER -- requirements
Module: axi_lite_mmio_master

Interface
REQ-001 SHALL have parameter AWPROT_VAL, default 3'b000: value driven on M_AXI_awprot.
REQ-002 SHALL have parameter ARPROT_VAL, default 3'b000: value driven on M_AXI_arprot.
REQ-003 SHALL have the following ports (name, direction, width, meaning):
- aclk  in  1  clock; all logic on rising edge
- arst_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when high with req_valid
- req_write  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- req_wstrb  in  4  write byte strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_rdata  out  32  read data; 0 for writes
- rsp_resp  out  2  AXI response code
- rsp_write  out  1  response belongs to a write
- M_AXI_awaddr/awprot/awvalid/awready  out/out/out/in  32/3/1/1  write address channel
- M_AXI_wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  write data channel
- M_AXI_bresp/bvalid/bready  in/in/out  2/1/1  write response channel
- M_AXI_araddr/arprot/arvalid/arready  out/out/out/in  32/3/1/1  read address channel
- M_AXI_rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  read data channel
- busy  out  1  high in any state other than IDLE

Function
REQ-004 SHALL implement the states IDLE, WR_AW_W, WR_B, RD_AR, RD_R and RSP.
REQ-005 SHALL drive req_ready=1 only in IDLE; a handshake SHALL capture addr/wdata/wstrb/write into registers in the same cycle.
REQ-006 SHALL transition from IDLE on handshake to WR_AW_W if req_write=1, else to RD_AR.
REQ-007 SHALL, on entering WR_AW_W, assert awvalid and wvalid together in the next cycle; each SHALL deassert independently the cycle after its own valid&ready handshake.
REQ-008 SHALL accept awready and wready in either order or in the same cycle; the transition to WR_B SHALL occur once both handshakes are done.
REQ-009 SHALL hold AXI valid signals and payloads stable until their handshake completes; the AXI payload SHALL be driven only from the captured registers.
REQ-010 SHALL drive bready=1 in WR_B; on bvalid it SHALL latch bresp, set rdata=0, set rsp_write=1 and go to RSP.
REQ-011 SHALL assert arvalid in RD_AR until arready, then go to RD_R.
REQ-012 SHALL drive rready=1 in RD_R; on rvalid it SHALL latch rdata and rresp, set rsp_write=0 and go to RSP.
REQ-013 SHALL, in RSP, hold rsp_valid=1 with stable outputs until rsp_ready, then return to IDLE.
REQ-014 SHALL produce responses that are registered outputs.
REQ-015 SHALL have minimum latency from req handshake to rsp_valid of 3 cycles when ready/valid are immediate: AW/W, B, then RSP.
REQ-016 SHALL keep at most one transaction outstanding; no new req SHALL be accepted before rsp handshake.
REQ-017 SHALL pass non-OKAY responses (SLVERR, DECERR) through unmodified and complete normally.
REQ-018 SHALL ignore bvalid and rvalid outside WR_B and RD_R respectively.

Reset
REQ-019 SHALL, while arst_n is low, set state=IDLE; all valids, bready, rready, rsp_valid, rsp_write and busy =0; all address, data and response registers =0.
REQ-020 SHALL abandon any transaction in progress when reset asserts mid-transaction; after release the block SHALL be in IDLE with req_ready=1.

Structure
REQ-021 SHALL define the state enum axi_master_state_t in const_pkg.
REQ-022 SHALL reuse the AXI_RESP_OKAY, AXI_RESP_SLVERR and AXI_RESP_DECERR constants from const_pkg.
REQ-023 SHALL be a single module with no sub-module.

Verification
REQ-024 Write 0x4600_0104, data 0xDEAD_BEEF, strb 0xF, with awready/wready tied 1 -> aw and w seen in the same cycle; bvalid=OKAY -> rsp_valid, rsp_resp=00, rsp_write=1, 3 cycles after the req handshake.
REQ-025 Write with wready 2 cycles before awready -> wvalid drops after its handshake, awvalid held with stable addr; exactly one transfer per channel.
REQ-026 Read 0x4600_0000 with arready delayed 4 cycles and rdata=0x0000_00A5, rresp=SLVERR -> rsp_rdata=0xA5, rsp_resp=10.
REQ-027 rsp_ready held low 5 cycles -> rsp outputs stable, req_ready=0; a new req_valid during this time is not accepted.
REQ-028 arst_n pulsed low while in WR_B -> all outputs return to reset values; a subsequent read completes correctly.
REQ-029 Spurious bvalid in IDLE -> no state change, rsp_valid stays 0.
